// File: rtl/stoch_signed_ndecode.sv
// Signed stochastic-to-binary decoder: counts p-m per channel over 2^COUNTER_SIZE
// enabled samples and publishes all channel sums together with a one-cycle strobe.
module stoch_signed_ndecode #(
    parameter int COUNTER_SIZE = 8,
    parameter int NUM_INPUTS   = 1,
    localparam int W           = COUNTER_SIZE + 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  EN,
    input  logic [NUM_INPUTS-1:0] as_p,
    input  logic [NUM_INPUTS-1:0] as_m,
    output logic [NUM_INPUTS*W-1:0] ys,
    output logic                  y_valid,
    output logic                  busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ACCUM = 1'b1;

    localparam logic signed [W-1:0] ONE = W'(1);

    logic [0:0]              state;
    logic [COUNTER_SIZE-1:0] cnt;
    logic signed [W-1:0]     acc [NUM_INPUTS];
    logic signed [W-1:0]     nxt [NUM_INPUTS];
    logic                    last;

    assign last = (cnt == '1);
    assign busy = (state == ACCUM);

    // Next sums include the current sample so the last-sample edge can load ys directly.
    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            nxt[i] = acc[i];
            if (as_p[i] && !as_m[i])
                nxt[i] = acc[i] + ONE;
            else if (!as_p[i] && as_m[i])
                nxt[i] = acc[i] - ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            ys      <= '0;
            y_valid <= 1'b0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++)
                acc[i] <= '0;
        end else begin
            y_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= ACCUM;
                        cnt   <= '0;
                        for (int unsigned i = 0; i < NUM_INPUTS; i++)
                            acc[i] <= '0;
                    end
                end
                default: begin
                    if (EN) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            y_valid <= 1'b1;
                            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                                ys[i*W +: W] <= nxt[i];
                                acc[i]       <= '0;
                            end
                            if (!START)
                                state <= IDLE;
                        end else begin
                            for (int unsigned i = 0; i < NUM_INPUTS; i++)
                                acc[i] <= nxt[i];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_signed_ndecode.sv
// Scoreboard bench for stoch_signed_ndecode with C=4, N=2: expected window sums are
// queued by the stimulus model and matched against ys on every y_valid pulse.
module tb_stoch_signed_ndecode;

    localparam int C = 4;
    localparam int N = 2;
    localparam int W = C + 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           START = 1'b0;
    logic           EN = 1'b0;
    logic [N-1:0]   as_p = '0;
    logic [N-1:0]   as_m = '0;
    logic [N*W-1:0] ys;
    logic           y_valid;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [N*W-1:0] sb [$];
    int             vq [$];

    // Reference model state
    logic           m_busy = 1'b0;
    int             m_cnt = 0;
    int             m_acc [N];
    logic [N*W-1:0] m_ys = '0;

    stoch_signed_ndecode #(.COUNTER_SIZE(C), .NUM_INPUTS(N)) dut (
        .CLK(CLK), .RST(RST), .START(START), .EN(EN),
        .as_p(as_p), .as_m(as_m), .ys(ys), .y_valid(y_valid), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (y_valid) begin
            vq.push_back(cyc);
            if (sb.size() == 0)
                chk("unexpected_valid", 32'd1, 32'd0);
            else
                chk("ys_result", 32'(ys), 32'(sb.pop_front()));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_acc[i] = 0;
    endtask

    // Drives one cycle, advances the model as the edge should, then checks registered outputs.
    task automatic drive(input logic s, input logic e, input logic [N-1:0] p, input logic [N-1:0] m);
        logic exp_valid;
        START = s; EN = e; as_p = p; as_m = m;
        exp_valid = 1'b0;
        if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                model_clear();
            end
        end else if (e) begin
            for (int i = 0; i < N; i++) begin
                if (p[i] && !m[i]) m_acc[i]++;
                else if (!p[i] && m[i]) m_acc[i]--;
            end
            if (m_cnt == (1 << C) - 1) begin
                for (int i = 0; i < N; i++) m_ys[i*W +: W] = W'(m_acc[i]);
                sb.push_back(m_ys);
                exp_valid = 1'b1;
                m_cnt = 0;
                model_clear();
                if (!s) m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        step();
        chk("busy", 32'(busy), 32'(m_busy));
        chk("y_valid", 32'(y_valid), 32'(exp_valid));
        chk("ys_hold", 32'(ys), 32'(m_ys));
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        for (int i = 0; i < n; i++) begin
            START = 1'($urandom); EN = 1'($urandom);
            as_p = N'($urandom); as_m = N'($urandom);
            step();
        end
        RST = 1'b0; START = 1'b0; EN = 1'b0; as_p = '0; as_m = '0;
        m_busy = 1'b0; m_cnt = 0; m_ys = '0;
        model_clear();
        chk("rst_ys", 32'(ys), 32'd0);
        chk("rst_valid", 32'(y_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ts;
        int n0;
        model_clear();

        // 1: reset, then START with no samples
        do_reset(2);
        drive(1'b1, 1'b0, '0, '0);
        chk("busy_after_start", 32'(busy), 32'd1);
        do_reset(1);

        // 2: full-scale, ch0 +16, ch1 -16
        vq.delete();
        ts = cyc + 1;
        drive(1'b1, 1'b1, 2'b11, 2'b00);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 2'b01, 2'b10);
        drive(1'b0, 1'b0, '0, '0);
        chk("fs_value", 32'(m_ys), 32'({6'b110000, 6'b010000}));
        chk("fs_npulse", 32'(vq.size()), 32'd1);
        if (vq.size() > 0) chk("fs_latency", 32'(vq[0] - ts), 32'd16);

        // 3: cancellation on ch0, alternation on ch1
        drive(1'b1, 1'b1, '0, '0);
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, {(i % 2 == 0), 1'b1}, 2'b01);
        drive(1'b0, 1'b0, '0, '0);
        chk("alt_value", 32'(m_ys), 32'({6'd8, 6'd0}));

        // 4: five stall cycles after sample 7, stall inputs ignored
        vq.delete();
        ts = cyc + 1;
        drive(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 2'b01, 2'b00);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 2'b11, 2'b00);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 2'b01, 2'b00);
        drive(1'b0, 1'b0, '0, '0);
        chk("stall_value", 32'(m_ys), 32'({6'd0, 6'd16}));
        if (vq.size() > 0) chk("stall_latency", 32'(vq[0] - ts), 32'd21);
        else chk("stall_npulse", 32'd0, 32'd1);

        // 5: ignored mid-window START, then back-to-back restart
        vq.delete();
        drive(1'b1, 1'b1, '0, '0);
        for (int i = 0; i < 16; i++)
            drive((i == 5) || (i == 15), 1'b1, 2'b01, 2'b00);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, '0, '0);
            if (i == 8) chk("b2b_ys_hold", 32'(ys), 32'({6'd0, 6'd16}));
            if (i < 15) chk("b2b_busy", 32'(busy), 32'd1);
        end
        drive(1'b0, 1'b0, '0, '0);
        chk("b2b_final", 32'(ys), 32'd0);
        chk("b2b_npulse", 32'(vq.size()), 32'd2);
        if (vq.size() == 2) chk("b2b_spacing", 32'(vq[1] - vq[0]), 32'd16);

        // 6: reset at sample 9 aborts, then a clean window
        vq.delete();
        drive(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 2'b01, 2'b10);
        do_reset(1);
        n0 = vq.size();
        chk("abort_nopulse", 32'(n0), 32'd0);
        drive(1'b0, 1'b1, 2'b11, 2'b00);
        chk("abort_idle", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 2'b10, 2'b00);
        drive(1'b0, 1'b0, '0, '0);
        chk("fresh_value", 32'(m_ys), 32'({6'd16, 6'd0}));
        chk("fresh_npulse", 32'(vq.size()), 32'd1);

        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
